// File: rtl/fifo128_sched_pkg.sv
// Shared constants and read-FSM encoding for the fifo128_sched block.
package fifo128_sched_pkg;
  localparam int DATA_W        = 128;
  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_FULL_LVL = FIFO_DEPTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/fifo128_sched_if.sv
// Requester, FIFO and AES-side signals of fifo128_sched; slave = scheduler side.
interface fifo128_sched_if;
  import fifo128_sched_pkg::*;

  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] fifo_in_data;
  logic              fifo_in_require, fifo_full;
  logic [DATA_W-1:0] fifo_out_data;
  logic              fifo_out_require, fifo_empty;
  logic              aes_valid;
  logic [DATA_W-1:0] aes_data;
  logic              aes_ready;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    input  fifo_full, fifo_out_data, fifo_empty, aes_ready,
    output req0_ready, req1_ready, fifo_in_data, fifo_in_require,
    output fifo_out_require, aes_valid, aes_data
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    output fifo_full, fifo_out_data, fifo_empty, aes_ready,
    input  req0_ready, req1_ready, fifo_in_data, fifo_in_require,
    input  fifo_out_require, aes_valid, aes_data
  );
endinterface

// File: rtl/fifo128_sched_arb.sv
// rr_arb2: 2-way combinational write arbiter. FIFO128_SCHED_FIXED_PRIO_EN selects
// fixed req0 priority (no state); otherwise round-robin on a last-grant bit.
module rr_arb2 (
`ifndef FIFO128_SCHED_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
`ifdef FIFO128_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end
  end
`else
  logic last_q, last_d;  // index of the requester granted most recently

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    last_d = last_q;
    if (gnt_o[0])      last_d = 1'b0;
    else if (gnt_o[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif
endmodule

// File: rtl/fifo128_sched.sv
// Two-requester write scheduler into an external FIFO plus a read FSM feeding AES.
// Build option: FIFO128_SCHED_FIXED_PRIO_EN (req0 absolute priority).
module fifo128_sched #(
  parameter int DATA_W = fifo128_sched_pkg::DATA_W
) (
  input logic           clk,
  input logic           rst_n,
  fifo128_sched_if.slave sif
);
  import fifo128_sched_pkg::*;

  logic [1:0] gnt;

  // rst_n gates the combinational outputs so they read zero throughout reset
  rr_arb2 u_arb (
`ifndef FIFO128_SCHED_FIXED_PRIO_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req_i ({sif.req1_valid, sif.req0_valid}),
    .en_i  (rst_n & ~sif.fifo_full),
    .gnt_o (gnt)
  );

  assign sif.req0_ready      = gnt[0];
  assign sif.req1_ready      = gnt[1];
  assign sif.fifo_in_require = |gnt;
  assign sif.fifo_in_data    = gnt[1] ? sif.req1_data : sif.req0_data;

  rd_state_e         state_q, state_d;
  logic              aes_valid_q, aes_valid_d;
  logic [DATA_W-1:0] aes_data_q, aes_data_d;
  logic              out_req;

  always_comb begin
    state_d     = state_q;
    aes_valid_d = aes_valid_q;
    aes_data_d  = aes_data_q;
    out_req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sif.fifo_empty) begin
          out_req = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        aes_data_d  = sif.fifo_out_data;
        aes_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (sif.aes_ready) begin
          aes_valid_d = 1'b0;
          if (!sif.fifo_empty) begin
            out_req = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aes_valid_q <= 1'b0;
      aes_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      aes_valid_q <= aes_valid_d;
      aes_data_q  <= aes_data_d;
    end
  end

  assign sif.fifo_out_require = out_req & rst_n;
  assign sif.aes_valid        = aes_valid_q;
  assign sif.aes_data         = aes_data_q;
endmodule

// File: doc/fifo128_sched.md
FIFO128_SCHED -- requirements
Module: fifo128_sched

Interface
REQ-001 SHALL have parameter: DATA_W, 128, width of every data bus (only 128 is supported).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1  requester has a word.
REQ-005 SHALL have ports: req0_data / req1_data  in  128  requester word.
REQ-006 SHALL have ports: req0_ready / req1_ready  out  1  word accepted this cycle.
REQ-007 SHALL have ports: fifo_in_data  out  128; fifo_in_require  out  1; fifo_full  in  1.
REQ-008 SHALL have ports: fifo_out_data  in  128; fifo_out_require  out  1; fifo_empty  in  1.
REQ-009 SHALL have ports: aes_valid  out  1; aes_data  out  128; aes_ready  in  1, a valid/ready handshake to the AES core.

Function
REQ-010 SHALL compute the write-side grant combinationally.
REQ-011 SHALL make no grant while fifo_full=1.
REQ-012 SHALL grant the single valid requester when only one is valid.
REQ-013 SHALL, when both are valid, grant the requester not granted last (round-robin).
REQ-014 SHALL, on a grant, assert fifo_in_require=1, drive fifo_in_data with the granted word, and assert that requester's ready only.
REQ-015 SHALL update the last-grant register only on a grant.
REQ-016 SHALL implement a read FSM with states IDLE, FETCH, HOLD.
REQ-017 In IDLE with fifo_empty=0, SHALL assert fifo_out_require for one cycle and go to FETCH; otherwise stay in IDLE.
REQ-018 In FETCH, SHALL register fifo_out_data into aes_data, set aes_valid=1, and go to HOLD.
REQ-019 In HOLD with aes_ready=0, SHALL keep aes_valid and aes_data stable.
REQ-020 In HOLD with aes_ready=1 and fifo_empty=0, SHALL assert fifo_out_require, clear aes_valid, and go to FETCH.
REQ-021 In HOLD with aes_ready=1 and fifo_empty=1, SHALL clear aes_valid and go to IDLE.
REQ-022 SHALL never assert fifo_out_require while fifo_empty=1 or in the FETCH state.
REQ-023 SHALL raise aes_valid exactly 3 rising edges after the edge accepting a word into an empty FIFO with the FSM in IDLE.
REQ-024 SHALL allow a write and a read request in the same cycle; that is legal and needs no special handling.
REQ-025 SHALL treat fifo_full as asserting at 7 stored words; a simultaneous write and read at full is not issued.

Reset
REQ-026 SHALL, while rst_n=0, drive aes_valid=0, aes_data=0, fifo_in_require=0, fifo_out_require=0, req0_ready=0 and req1_ready=0.
REQ-027 SHALL reset the FSM to IDLE and set last-grant=1, so req0 wins the first contention.
REQ-028 SHALL discard an in-flight FETCH or HOLD word on reset mid-operation.

Configuration
REQ-029 SHALL support macro FIFO128_SCHED_FIXED_PRIO_EN.
REQ-030 With FIFO128_SCHED_FIXED_PRIO_EN defined, SHALL give req0 absolute priority and remove the last-grant register.
REQ-031 Without FIFO128_SCHED_FIXED_PRIO_EN, SHALL use round-robin per REQ-013.

Structure
REQ-032 SHALL place DATA_W, the FSM state encoding and the FIFO depth constant (8) in shared package fifo128_sched_pkg.
REQ-033 SHALL implement arbitration in sub-module rr_arb2 (2-way arbiter, grant vector out, last-grant register inside).

Verification
REQ-034 SHALL cover: req0 alone sends 128'h0011...EEFF, aes_ready=1 -> aes_valid rises 3 edges later with aes_data=128'h0011...EEFF.
REQ-035 SHALL cover: both requesters valid for 4 cycles (req0 0xA0..A3, req1 0xB0..B3) -> aes_data order A0,B0,A1,B1; FIXED_PRIO build -> A0..A3 first.
REQ-036 SHALL cover: aes_ready=0, 9 writes offered -> 7 accepted plus 1 held in HOLD, readies drop on full, no overflow, no fifo_in_require while full.
REQ-037 SHALL cover: aes_ready toggling 1/0 each cycle over 5 words -> all 5 delivered in order, aes_data stable while aes_valid=1 and aes_ready=0.
REQ-038 SHALL cover: rst_n pulsed low during HOLD -> aes_valid=0 immediately, FSM in IDLE, next contention granted to req0.
REQ-039 SHALL cover: empty FIFO in IDLE for 20 cycles -> fifo_out_require never asserted.
